// File: rtl/grid_matrix_driver_pkg.sv
// ============================================================================
// Module   : grid_matrix_driver_pkg
// Brief    : Shared grid geometry, scan FSM encoding and cell index helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package grid_matrix_driver_pkg;

   localparam int DEF_ROWS        = 16;
   localparam int DEF_COLS        = 16;
   localparam int DEF_GRID_BITS   = DEF_ROWS * DEF_COLS;
   localparam int DEF_CLK_DIV     = 4;
   localparam int DEF_HOLD_CYCLES = 1024;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_LATCH = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

   // Playfield layout is column-major: all rows of column 0 first.
   function automatic int cell_idx(input int col, input int row, input int rows);
      return col * rows + row;
   endfunction

endpackage

`default_nettype wire

// File: rtl/grid_matrix_driver_if.sv
// ============================================================================
// Module   : grid_matrix_driver_if
// Brief    : Playfield input and LED column/row driver outputs of the scanner.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface grid_matrix_driver_if
   import grid_matrix_driver_pkg::*;
#(
   parameter int ROWS = DEF_ROWS,
   parameter int COLS = DEF_COLS
) ();

   localparam int GRID_BITS = ROWS * COLS;
   localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic                 enable;
   logic [GRID_BITS-1:0] grid_in;
   logic                 ser_data;
   logic                 ser_clk;
   logic                 ser_latch;
   logic [ROW_W-1:0]     row_sel;
   logic                 row_oe;
   logic                 frame_done;

   // Grid engine side.
   modport master (
      output enable, grid_in,
      input  ser_data, ser_clk, ser_latch, row_sel, row_oe, frame_done
   );

   // Scanner side.
   modport slave (
      input  enable, grid_in,
      output ser_data, ser_clk, ser_latch, row_sel, row_oe, frame_done
   );

endinterface

`default_nettype wire

// File: rtl/grid_matrix_driver_ser_tick_gen.sv
// ============================================================================
// Module   : ser_tick_gen
// Brief    : CLK_DIV prescaler giving the ser_clk half-period tick and phase.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ser_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run_i,
   output logic tick_o,
   output logic phase_o
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] div_q;
   logic             phase_q;

   assign tick_o  = run_i && (div_q == DIV_W'(CLK_DIV - 1));
   assign phase_o = phase_q;

   // Held cleared while idle so every shift burst starts on a low phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q   <= '0;
         phase_q <= 1'b0;
      end else if (!run_i) begin
         div_q   <= '0;
         phase_q <= 1'b0;
      end else if (tick_o) begin
         div_q   <= '0;
         phase_q <= ~phase_q;
      end else begin
         div_q   <= div_q + DIV_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/grid_matrix_driver.sv
// ============================================================================
// Module   : grid_matrix_driver
// Brief    : Row-scanning LED matrix driver with per-frame playfield snapshot.
// Revision : 1.0
// ============================================================================
`default_nettype none

module grid_matrix_driver
   import grid_matrix_driver_pkg::*;
#(
   parameter int ROWS        = DEF_ROWS,
   parameter int COLS        = DEF_COLS,
   parameter int CLK_DIV     = DEF_CLK_DIV,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset,
   grid_matrix_driver_if.slave  bus
);

   localparam int GRID_BITS = ROWS * COLS;
   localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int BIT_W     = $clog2(COLS);
   localparam int IDX_W     = $clog2(GRID_BITS);
   localparam int CNT_W     = $clog2(HOLD_CYCLES + CLK_DIV + 1);

   state_t               state_q;
   logic [ROW_W-1:0]     row_q;
   logic [BIT_W-1:0]     bit_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [GRID_BITS-1:0] frame_q;
   logic [COLS-1:0]      shift_q;
   logic                 ser_data_q;
   logic                 ser_clk_q;
   logic                 ser_latch_q;
   logic [ROW_W-1:0]     row_sel_q;
   logic                 row_oe_q;
   logic                 frame_done_q;

   logic [GRID_BITS-1:0] src_d;
   logic [COLS-1:0]      row_bits_d;
   logic [ROW_W-1:0]     row_next_d;
   logic [IDX_W-1:0]     idx_d;
   logic                 shift_run;
   logic                 tick;
   logic                 phase;

   assign shift_run = (state_q == ST_SHIFT);

   ser_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk     (clk),
      .reset   (reset),
      .run_i   (shift_run),
      .tick_o  (tick),
      .phase_o (phase)
   );

   // Row 0 reads the live bus so the fresh snapshot is shown on that same row.
   always_comb begin
      src_d      = (row_q == '0) ? bus.grid_in : frame_q;
      row_bits_d = '0;
      idx_d      = '0;
      for (int c = 0; c < COLS; c++) begin
         idx_d         = IDX_W'(cell_idx(c, int'(row_q), ROWS));
         row_bits_d[c] = src_d[idx_d];
      end
      row_next_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         row_q        <= '0;
         bit_q        <= '0;
         cnt_q        <= '0;
         frame_q      <= '0;
         shift_q      <= '0;
         ser_data_q   <= 1'b0;
         ser_clk_q    <= 1'b0;
         ser_latch_q  <= 1'b0;
         row_sel_q    <= '0;
         row_oe_q     <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               ser_data_q  <= 1'b0;
               ser_clk_q   <= 1'b0;
               ser_latch_q <= 1'b0;
               row_sel_q   <= '0;
               row_oe_q    <= 1'b0;
               if (bus.enable) begin
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (row_q == '0) begin
                  frame_q <= bus.grid_in;
               end
               ser_data_q <= row_bits_d[COLS-1];
               shift_q    <= {row_bits_d[COLS-2:0], 1'b0};
               ser_clk_q  <= 1'b0;
               bit_q      <= '0;
               state_q    <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (tick) begin
                  if (!phase) begin
                     ser_clk_q <= 1'b1;
                  end else begin
                     ser_clk_q <= 1'b0;
                     if (bit_q == BIT_W'(COLS - 1)) begin
                        ser_data_q  <= 1'b0;
                        ser_latch_q <= 1'b1;
                        row_sel_q   <= row_q;
                        cnt_q       <= '0;
                        state_q     <= ST_LATCH;
                     end else begin
                        ser_data_q <= shift_q[COLS-1];
                        shift_q    <= {shift_q[COLS-2:0], 1'b0};
                        bit_q      <= bit_q + BIT_W'(1);
                     end
                  end
               end
            end
            ST_LATCH: begin
               if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                  ser_latch_q <= 1'b0;
                  row_oe_q    <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= ST_HOLD;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                  row_oe_q     <= 1'b0;
                  cnt_q        <= '0;
                  row_q        <= row_next_d;
                  frame_done_q <= (row_q == ROW_W'(ROWS - 1));
                  if (bus.enable) begin
                     state_q <= ST_LOAD;
                  end else begin
                     row_sel_q <= '0;
                     state_q   <= ST_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ser_data   = ser_data_q;
   assign bus.ser_clk    = ser_clk_q;
   assign bus.ser_latch  = ser_latch_q;
   assign bus.row_sel    = row_sel_q;
   assign bus.row_oe     = row_oe_q;
   assign bus.frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_grid_matrix_driver.sv
// ============================================================================
// Module   : tb_grid_matrix_driver
// Brief    : Directed self-checking bench for the LED matrix scanner.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_grid_matrix_driver;

   localparam int ROWS       = 16;
   localparam int COLS       = 16;
   localparam int CLK_DIV    = 4;
   localparam int HOLD       = 1024;
   localparam int ROW_PERIOD = 1157;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   grid_matrix_driver_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

   grid_matrix_driver #(
      .ROWS        (ROWS),
      .COLS        (COLS),
      .CLK_DIV     (CLK_DIV),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [8:0] outs;
   assign outs = {bus.ser_data, bus.ser_clk, bus.ser_latch, bus.row_sel, bus.row_oe, bus.frame_done};

   // Observer: reconstructs each shifted row word and tracks latch/hold/frame events.
   logic [15:0] words [3][16];
   int          lcnt [3][16];
   int          nbits_at [16];
   int          latch_len [16];
   int          oe_len [16];
   logic [15:0] word_q;
   logic [3:0]  oe_row;
   int          nbits, latch_run, oe_run, fd_count, fd_cyc, fidx;
   logic        prev_sclk, prev_latch, prev_oe;

   always_comb fidx = (fd_count > 2) ? 2 : fd_count;

   always @(negedge clk) begin
      if (reset) begin
         for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < 16; r++) begin
               words[f][r] <= '0;
               lcnt[f][r]  <= 0;
            end
         end
         for (int r = 0; r < 16; r++) begin
            nbits_at[r]  <= 0;
            latch_len[r] <= 0;
            oe_len[r]    <= 0;
         end
         word_q <= '0; oe_row <= '0;
         nbits <= 0; latch_run <= 0; oe_run <= 0; fd_count <= 0; fd_cyc <= 0;
         prev_sclk <= 1'b0; prev_latch <= 1'b0; prev_oe <= 1'b0;
      end else begin
         prev_sclk  <= bus.ser_clk;
         prev_latch <= bus.ser_latch;
         prev_oe    <= bus.row_oe;
         if (bus.ser_clk && !prev_sclk) begin
            word_q <= {word_q[14:0], bus.ser_data};
            nbits  <= nbits + 1;
         end
         if (bus.ser_latch && !prev_latch) begin
            words[fidx][bus.row_sel] <= word_q;
            lcnt[fidx][bus.row_sel]  <= lcnt[fidx][bus.row_sel] + 1;
            nbits_at[bus.row_sel]    <= nbits;
            nbits                    <= 0;
         end
         if (bus.ser_latch) begin
            latch_run <= latch_run + 1;
         end else if (prev_latch) begin
            latch_len[bus.row_sel] <= latch_run;
            latch_run              <= 0;
         end
         if (bus.row_oe) begin
            oe_run <= oe_run + 1;
            oe_row <= bus.row_sel;
         end else if (prev_oe) begin
            oe_len[oe_row] <= oe_run;
            oe_run         <= 0;
         end
         if (bus.frame_done) begin
            fd_count <= fd_count + 1;
            fd_cyc   <= cyc;
         end
      end
   end

   task automatic test_reset();
      int k;
      reset = 1'b1; bus.enable = 1'b0; bus.grid_in = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (outs !== 9'd0) begin
         n_fail++; $display("FAIL reset_state: outputs=%h required=000", outs);
      end
      reset = 1'b0; bus.enable = 1'b1; bus.grid_in = 256'd1;
      for (k = 0; k < 2000 && bus.row_oe !== 1'b1; k++) @(negedge clk);
      n_checks++;
      if (bus.row_oe !== 1'b1) begin
         n_fail++; $display("FAIL reach_hold: row_oe=%b required=1", bus.row_oe);
      end
      repeat (100) @(negedge clk);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (outs !== 9'd0) begin
         n_fail++; $display("FAIL async_reset_mid_hold: outputs=%h required=000", outs);
      end
      bus.enable = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (outs !== 9'd0) begin
         n_fail++; $display("FAIL idle_after_release: outputs=%h required=000", outs);
      end
      bus.enable = 1'b1;
      for (k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (bus.ser_clk === 1'b1) break;
      end
      n_checks++;
      if (k != CLK_DIV + 1) begin
         n_fail++; $display("FAIL first_ser_clk_rise: cycle=%0d required=%0d", k, CLK_DIV + 1);
      end
      reset = 1'b1; bus.enable = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_frame();
      int k, t0;
      logic [255:0] g;
      logic [15:0]  exp_w;
      bus.grid_in = '0;
      bus.grid_in[0]   = 1'b1;
      bus.grid_in[255] = 1'b1;
      @(negedge clk); bus.enable = 1'b1;
      @(negedge clk); t0 = cyc;
      for (k = 0; k < 2000 && lcnt[0][0] != 1; k++) @(negedge clk);
      n_checks++;
      if (lcnt[0][0] != 1 || bus.row_sel !== 4'd0) begin
         n_fail++; $display("FAIL row0_latch: count=%0d row_sel=%0d required 1/0", lcnt[0][0], bus.row_sel);
      end
      // Diagonal pattern written mid-frame must not appear before the next frame.
      g = '0;
      for (int c = 0; c < 16; c++) g = g | (256'd1 << (17 * c));
      bus.grid_in = g;
      for (k = 0; k < 20000 && fd_count < 1; k++) @(negedge clk);
      n_checks++;
      if (fd_cyc - t0 != ROWS * ROW_PERIOD) begin
         n_fail++; $display("FAIL frame_done_time: cycles=%0d required=%0d", fd_cyc - t0, ROWS * ROW_PERIOD);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (fd_count != 1 || bus.frame_done !== 1'b0) begin
         n_fail++; $display("FAIL frame_done_pulse: count=%0d level=%b required 1/0", fd_count, bus.frame_done);
      end
      for (int r = 0; r < 16; r++) begin
         exp_w = (r == 0) ? 16'h0001 : ((r == 15) ? 16'h8000 : 16'h0000);
         n_checks++;
         if (lcnt[0][r] != 1 || words[0][r] !== exp_w || nbits_at[r] != COLS) begin
            n_fail++;
            $display("FAIL frameA_row%0d: latches=%0d word=%h bits=%0d required 1/%h/16", r, lcnt[0][r], words[0][r], nbits_at[r], exp_w);
         end
         n_checks++;
         if (oe_len[r] != HOLD) begin
            n_fail++; $display("FAIL hold_len_row%0d: cycles=%0d required=%0d", r, oe_len[r], HOLD);
         end
      end
      n_checks++;
      if (latch_len[0] != CLK_DIV) begin
         n_fail++; $display("FAIL latch_len: cycles=%0d required=%0d", latch_len[0], CLK_DIV);
      end
      for (k = 0; k < 2000 && lcnt[1][0] != 1; k++) @(negedge clk);
      n_checks++;
      if (lcnt[1][0] != 1 || bus.row_sel !== 4'd0) begin
         n_fail++; $display("FAIL wrap_to_row0: count=%0d row_sel=%0d required 1/0", lcnt[1][0], bus.row_sel);
      end
   endtask

   task automatic test_snapshot();
      int k;
      logic [15:0] exp_w;
      for (k = 0; k < 8000 && lcnt[1][5] != 1; k++) @(negedge clk);
      n_checks++;
      if (lcnt[1][5] != 1) begin
         n_fail++; $display("FAIL reach_row5: count=%0d required=1", lcnt[1][5]);
      end
      bus.grid_in = '1;
      for (k = 0; k < 20000 && fd_count < 2; k++) @(negedge clk);
      for (int r = 0; r < 16; r++) begin
         exp_w = 16'h0001 << r;
         n_checks++;
         if (lcnt[1][r] != 1 || words[1][r] !== exp_w) begin
            n_fail++; $display("FAIL frameB_row%0d: latches=%0d word=%h required 1/%h", r, lcnt[1][r], words[1][r], exp_w);
         end
      end
      for (k = 0; k < 2000 && lcnt[2][0] != 1; k++) @(negedge clk);
      n_checks++;
      if (words[2][0] !== 16'hFFFF) begin
         n_fail++; $display("FAIL frameC_row0: word=%h required=ffff", words[2][0]);
      end
   endtask

   task automatic test_enable_drop();
      int k;
      for (k = 0; k < 4000 && lcnt[2][2] != 1; k++) @(negedge clk);
      for (k = 0; k < 100 && bus.row_oe !== 1'b1; k++) @(negedge clk);
      for (k = 0; k < 1100 && bus.row_oe !== 1'b0; k++) @(negedge clk);
      repeat (30) @(negedge clk);
      bus.enable = 1'b0;
      for (k = 0; k < 200 && lcnt[2][3] != 1; k++) @(negedge clk);
      n_checks++;
      if (lcnt[2][3] != 1 || bus.row_sel !== 4'd3) begin
         n_fail++; $display("FAIL row3_completes: count=%0d row_sel=%0d required 1/3", lcnt[2][3], bus.row_sel);
      end
      for (k = 0; k < 20 && bus.row_oe !== 1'b1; k++) @(negedge clk);
      for (k = 0; k < 1100 && bus.row_oe !== 1'b0; k++) @(negedge clk);
      repeat (50) @(negedge clk);
      n_checks++;
      if (outs !== 9'd0 || lcnt[2][4] != 0) begin
         n_fail++; $display("FAIL idle_after_drop: outputs=%h row4_latches=%0d required 000/0", outs, lcnt[2][4]);
      end
      n_checks++;
      if (oe_len[3] != HOLD) begin
         n_fail++; $display("FAIL row3_hold_len: cycles=%0d required=%0d", oe_len[3], HOLD);
      end
      bus.enable = 1'b1;
      for (k = 0; k < 300 && lcnt[2][4] != 1; k++) @(negedge clk);
      n_checks++;
      if (lcnt[2][4] != 1 || bus.row_sel !== 4'd4) begin
         n_fail++; $display("FAIL resume_row4: count=%0d row_sel=%0d required 1/4", lcnt[2][4], bus.row_sel);
      end
      n_checks++;
      if (words[2][4] !== 16'hFFFF || words[2][3] !== 16'hFFFF) begin
         n_fail++; $display("FAIL resume_data: row3=%h row4=%h required ffff/ffff", words[2][3], words[2][4]);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_snapshot();
      test_enable_drop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
